// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the writeback port arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register address / data widths, the grant encoding, and the
// record type stored in the mul/div result buffer.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef enum logic {
        GNT_PIPE = 1'b0,
        GNT_MD   = 1'b1
    } gnt_e;

    // One buffered mul/div result: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } md_res_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of every handshake and bus signal around the writeback arbiter.
// Latency: n/a (wiring only).
// Backpressure: readies are driven by the arbiter (slave modport).
//
// Groups: pipeline writeback (valid/rd/data/ready), mul/div issue
// (valid/rd/ready), mul/div result (valid/rd/data/ready), decode operands
// with stall_hazard, register file write port, and the busy_mask scoreboard.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  pipe_wr_valid;
    logic [REG_ADDR_W-1:0] pipe_wr_rd;
    logic [XLEN-1:0]       pipe_wr_data;
    logic                  pipe_wr_ready;

    logic                  md_issue_valid;
    logic [REG_ADDR_W-1:0] md_issue_rd;
    logic                  md_issue_ready;

    logic                  md_res_valid;
    logic [REG_ADDR_W-1:0] md_res_rd;
    logic [XLEN-1:0]       md_res_data;
    logic                  md_res_ready;

    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  stall_hazard;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic [NUM_REGS-1:0]   busy_mask;

    // Arbiter side.
    modport slave (
        input  pipe_wr_valid, pipe_wr_rd, pipe_wr_data,
        output pipe_wr_ready,
        input  md_issue_valid, md_issue_rd,
        output md_issue_ready,
        input  md_res_valid, md_res_rd, md_res_data,
        output md_res_ready,
        input  dec_rs1, dec_rs2, dec_rd,
        output stall_hazard,
        output rf_we, rf_waddr, rf_wdata, busy_mask
    );

    // Core / environment side.
    modport master (
        output pipe_wr_valid, pipe_wr_rd, pipe_wr_data,
        input  pipe_wr_ready,
        output md_issue_valid, md_issue_rd,
        input  md_issue_ready,
        output md_res_valid, md_res_rd, md_res_data,
        input  md_res_ready,
        output dec_rs1, dec_rs2, dec_rd,
        input  stall_hazard,
        input  rf_we, rf_waddr, rf_wdata, busy_mask
    );

endinterface

// File: rtl/wb_result_fifo.sv
// In-order buffer for mul/div results awaiting a register file write slot.
// Latency: an entry pushed at edge N is visible at the head in cycle N+1.
// Backpressure: a push while full is dropped unless a pop happens the same cycle.
//
// Ports: clk, rst (sync, active-high); push/push_dat in; pop in with
// pop_dat = current head; full/empty status.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  md_res_t push_dat,
    input  logic    pop,
    output md_res_t pop_dat,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    md_res_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register file write port between the pipeline and mul/div results, with an rd scoreboard.
// Latency: a grant in cycle N drives rf_we/rf_waddr/rf_wdata in cycle N+1.
// Backpressure: pipe_wr_ready low on MD grants; md_res_ready low when the result FIFO is full; md_issue_ready low while rd is busy.
//
// Ports: clk, rst (sync, active-high); bus (wb_port_arbiter_if.slave) carrying
// the pipe writeback, md issue and md result handshakes, decode operands and
// stall_hazard, the register file write port and busy_mask.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    md_res_t               fifo_in;
    md_res_t               fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  md_push;
    logic                  md_pop;

    gnt_e                  gnt;
    logic                  pipe_fire;
    logic                  issue_fire;
    logic [CNT_W-1:0]      starve_cnt;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_nxt;

    logic                  wr_sel;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    // ---------------- result buffer ----------------
    assign fifo_in.rd    = bus.md_res_rd;
    assign fifo_in.data  = bus.md_res_data;
    assign md_push       = bus.md_res_valid && !fifo_full;
    assign bus.md_res_ready = !fifo_full;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (md_push),
        .push_dat (fifo_in),
        .pop      (md_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ---------------- arbitration ----------------
    // MD wins when the pipe is idle, or once the pipe has had STARVE_MAX
    // consecutive grants while a result waited.
    assign gnt = (!fifo_empty && (!bus.pipe_wr_valid || starve_cnt == CNT_MAX))
                 ? GNT_MD : GNT_PIPE;

    assign md_pop            = (gnt == GNT_MD);
    assign bus.pipe_wr_ready = (gnt == GNT_PIPE);
    assign pipe_fire         = bus.pipe_wr_valid && bus.pipe_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || md_pop) begin
            starve_cnt <= '0;
        end else if (pipe_fire && starve_cnt < CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // ---------------- write port ----------------
    always_comb begin
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (md_pop) begin
            wr_sel  = 1'b1;
            wr_addr = fifo_head.rd;
            wr_data = fifo_head.data;
        end else if (pipe_fire) begin
            wr_sel  = 1'b1;
            wr_addr = bus.pipe_wr_rd;
            wr_data = bus.pipe_wr_data;
        end
    end

    // x0 writes still consume the grant but never reach the register file.
    assign wr_en = wr_sel && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= wr_en;
            if (wr_en) begin
                bus.rf_waddr <= wr_addr;
                bus.rf_wdata <= wr_data;
            end
        end
    end

    // ---------------- scoreboard ----------------
    assign bus.md_issue_ready = !busy_q[bus.md_issue_rd];
    assign issue_fire         = bus.md_issue_valid && bus.md_issue_ready;

    // Clear first, then set: a set and a clear of different bits both land.
    // The same bit cannot be both, since an issue to a busy rd is refused.
    always_comb begin
        busy_nxt = busy_q;
        if (md_pop) begin
            busy_nxt[fifo_head.rd] = 1'b0;
        end
        if (issue_fire && bus.md_issue_rd != '0) begin
            busy_nxt[bus.md_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign bus.busy_mask    = busy_q;
    assign bus.stall_hazard = busy_q[bus.dec_rs1] | busy_q[bus.dec_rs2] | busy_q[bus.dec_rd];

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the number of consecutive pipeline grants allowed while a mul/div result is waiting.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: the number of mul/div result buffer entries.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 reset (synchronous, active-high, sampled on posedge clk).
REQ-004 SHALL have ports: pipe_wr_valid in 1; pipe_wr_rd in 5; pipe_wr_data in 32; pipe_wr_ready out 1, the pipeline writeback handshake.
REQ-005 SHALL have ports: md_issue_valid in 1; md_issue_rd in 5; md_issue_ready out 1, the mul/div issue handshake that marks rd pending.
REQ-006 SHALL have ports: md_res_valid in 1; md_res_rd in 5; md_res_data in 32; md_res_ready out 1, the mul/div result handshake.
REQ-007 SHALL have ports: dec_rs1, dec_rs2, dec_rd in 5 each (decode-stage operands); stall_hazard out 1.
REQ-008 SHALL have ports: rf_we out 1; rf_waddr out 5; rf_wdata out 32, which drive the register file write port; busy_mask out 32, the scoreboard.

Function
REQ-009 SHALL complete a transfer on each handshake when valid and ready are both high at posedge clk.
REQ-010 SHALL buffer accepted md results in a FIFO_DEPTH-entry FIFO; md_res_ready = FIFO not full (combinational).
REQ-011 SHALL decide arbitration each cycle: grant MD if the FIFO is non-empty and (pipe_wr_valid is low or starve_cnt == STARVE_MAX); otherwise grant PIPE.
REQ-012 SHALL drive pipe_wr_ready low only in cycles where MD is granted while the FIFO is non-empty.
REQ-013 SHALL register rf_we/rf_waddr/rf_wdata: a grant in cycle N appears on the write port in cycle N+1 (latency 1).
REQ-014 SHALL, for a granted write with rd == 0, drop the write (rf_we stays 0); the handshake still completes, and for an MD grant the FIFO still pops.
REQ-015 SHALL update starve_cnt as follows: increment (saturating at STARVE_MAX) on a PIPE grant while the FIFO is non-empty; clear on an MD grant or when the FIFO is empty.
REQ-016 SHALL set busy_mask[rd] on an md issue handshake with rd != 0, and clear busy_mask[rd] when the MD grant for that rd is issued.
REQ-017 SHALL drive md_issue_ready = !busy_mask[md_issue_rd] so that a second in-flight op to the same rd is refused.
REQ-018 SHALL, when a set and a clear of different bits occur in the same cycle, apply both.
REQ-019 SHALL drive stall_hazard = busy_mask[dec_rs1] | busy_mask[dec_rs2] | busy_mask[dec_rd] (combinational), with busy_mask[0] hard-wired to 0.
REQ-020 SHALL allow a FIFO push and pop in the same cycle when full; md_res_ready stays low while full, and the pop frees an entry for the next cycle.
REQ-021 SHALL write FIFO entries in arrival order, with no reordering between md results.

Reset
REQ-022 SHALL, on rst, clear the FIFO (empty), starve_cnt=0, busy_mask=0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-023 SHALL make all ready outputs reflect the reset state (empty FIFO, clear scoreboard) in the cycle after rst deasserts: md_res_ready=1, md_issue_ready=1, pipe_wr_ready=1.
REQ-024 SHALL discard any in-flight FIFO entry when rst is asserted mid-operation; no write for it ever appears.

Structure
REQ-025 SHALL place the shared package constants REG_ADDR_W=5, XLEN=32 and the grant enum {GNT_PIPE, GNT_MD} in the core's common package.
REQ-026 SHALL implement the result buffer as the sub-module wb_result_fifo (parameter DEPTH, with push/pop/full/empty).
REQ-027 SHALL keep the arbiter and scoreboard in wb_port_arbiter itself.

Verification
REQ-028 SHALL cover: pipe write rd=5, data 0xDEADBEEF, with the FIFO empty -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-029 SHALL cover: md issue rd=7, then dec_rs1=7 -> stall_hazard=1 and busy_mask=0x80; md result rd=7 with pipe idle -> write appears 2 cycles after the result handshake, busy_mask returns to 0, stall_hazard=0.
REQ-030 SHALL cover: FIFO holds one result while pipe_wr_valid is held high for 10 cycles -> 4 PIPE grants, then pipe_wr_ready=0 for one cycle while the MD write goes out, then PIPE resumes.
REQ-031 SHALL cover: md issue rd=9 while rd=9 is already pending -> md_issue_ready=0 until the rd=9 result is granted.
REQ-032 SHALL cover: 3 back-to-back md results with the pipe continuously writing -> md_res_ready drops after 2, no data is lost, and writes occur in arrival order.
REQ-033 SHALL cover: rst asserted with the FIFO full -> rf_we stays 0 afterwards, busy_mask=0, md_res_ready=1.
